// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one line-wide memory request/response port.
//   addr  : request address (byte address)
//   read  : read strobe, held until resp
//   write : write strobe, held until resp
//   wdata : write line
//   rdata : read line, qualified by resp
//   resp  : one-cycle completion pulse
// The master modport issues requests (an L1 cache, or the arbiter toward L2);
// the slave modport services them.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LINE_W = 128
);
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;

    modport master (output addr, read, write, wdata, input rdata, resp);
    modport slave  (input addr, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared L2 to either the I-side or the D-side L1 cache,
// one transaction at a time, with round-robin priority on contention.
//   clk         : clock, rising-edge state updates
//   reset       : asynchronous active-high reset
//   i_bus       : I-side L1 port (slave)
//   d_bus       : D-side L1 port (slave)
//   l2_bus      : unified L2 port (master)
//   busy        : high while a side is being served
//   i_grant_cnt : saturating count of I-side grants
//   d_grant_cnt : saturating count of D-side grants
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LINE_W = 128
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  i_bus,
    mem_arbiter_if.slave  d_bus,
    mem_arbiter_if.master l2_bus,
    output logic          busy,
    output logic [15:0]   i_grant_cnt,
    output logic [15:0]   d_grant_cnt
);

    typedef enum logic [1:0] {StIdle, StServeI, StServeD, StRecover} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;    // 0: I granted last, 1: D granted last
    logic [15:0] i_cnt_q, i_cnt_d;
    logic [15:0] d_cnt_q, d_cnt_d;

    logic              i_req, d_req;
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_wdata;
    logic              sel_read, sel_write;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign i_req = i_bus.read | i_bus.write;
    assign d_req = d_bus.read | d_bus.write;

    // Read data is broadcast; only resp tells a side the line is for it.
    assign i_bus.rdata = l2_bus.rdata;
    assign d_bus.rdata = l2_bus.rdata;

    assign busy        = (state_q == StServeI) || (state_q == StServeD);
    assign i_grant_cnt = i_cnt_q;
    assign d_grant_cnt = d_cnt_q;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        i_cnt_d   = i_cnt_q;
        d_cnt_d   = d_cnt_q;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        i_bus.resp = 1'b0;
        d_bus.resp = 1'b0;

        unique case (state_q)
            StIdle: begin
                // I wins when alone, or on contention if D was granted last.
                if (i_req && (!d_req || last_q)) begin
                    state_d = StServeI;
                    last_d  = 1'b0;
                    i_cnt_d = sat_inc(i_cnt_q);
                end else if (d_req) begin
                    state_d = StServeD;
                    last_d  = 1'b1;
                    d_cnt_d = sat_inc(d_cnt_q);
                end
            end
            StServeI: begin
                sel_addr   = i_bus.addr;
                sel_wdata  = i_bus.wdata;
                sel_write  = i_bus.write;
                sel_read   = i_bus.read & ~i_bus.write;  // write wins
                i_bus.resp = l2_bus.resp;
                if (l2_bus.resp) state_d = StRecover;
            end
            StServeD: begin
                sel_addr   = d_bus.addr;
                sel_wdata  = d_bus.wdata;
                sel_write  = d_bus.write;
                sel_read   = d_bus.read & ~d_bus.write;  // write wins
                d_bus.resp = l2_bus.resp;
                if (l2_bus.resp) state_d = StRecover;
            end
            StRecover: begin
                // Dead cycle lets the finished requester drop its strobes.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        l2_bus.addr  = sel_addr;
        l2_bus.wdata = sel_wdata;
        l2_bus.read  = sel_read;
        l2_bus.write = sel_write;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            i_cnt_q <= 16'd0;
            d_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            i_cnt_q <= i_cnt_d;
            d_cnt_q <= d_cnt_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-into-one arbiter between the instruction-side and data-side L1 caches of the pipelined LC-3b core and the shared unified L2 cache. It grants one L1 miss/writeback transaction at a time, routes address, data and response to and from the granted side, and alternates priority round-robin when both sides contend. Grant counts per side are kept for performance inspection.

## Interface
- ADDR_W, 16, address width (byte address)
- LINE_W, 128, cache line width in bits
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- i_addr  in  ADDR_W  I-side L1 request address
- i_read / i_write  in  1 each  I-side request strobes, held until i_resp
- i_wdata  in  LINE_W  I-side write line
- i_rdata  out  LINE_W  read line to I-side
- i_resp  out  1  one-cycle completion pulse to I-side
- d_addr, d_read, d_write, d_wdata, d_rdata, d_resp  same widths/meaning for D-side
- l2_addr  out  ADDR_W  address to L2
- l2_read / l2_write  out  1 each  strobes to L2, held until l2_resp
- l2_wdata  out  LINE_W  write line to L2
- l2_rdata  in  LINE_W  read line from L2
- l2_resp  in  1  L2 completion pulse
- busy  out  1  high while in a SERVE state
- i_grant_cnt / d_grant_cnt  out  16 each  saturating grant counters

## Operation
- States: IDLE, SERVE_I, SERVE_D, RECOVER. Registered state; `last` bit (0 = I granted last, 1 = D granted last).
- IDLE: i_req = i_read|i_write, d_req = d_read|d_write. Only i_req -> SERVE_I. Only d_req -> SERVE_D. Both -> side not equal to `last` (last=1 -> SERVE_I, last=0 -> SERVE_D). Neither -> stay.
- On entering SERVE_x: `last` <= x; x_grant_cnt increments, saturating at 16'hFFFF.
- SERVE_x: l2_addr/l2_wdata/l2_read/l2_write driven combinationally from side x. If requester asserts both read and write, l2_write=1, l2_read=0 (write wins). x_resp = l2_resp; other side's resp = 0. On l2_resp -> RECOVER.
- RECOVER: one dead cycle so requester can drop its strobes; all strobes/resps 0; -> IDLE unconditionally.
- i_rdata and d_rdata both equal l2_rdata at all times; only resp qualifies them.
- In IDLE/RECOVER: l2_read=l2_write=0, l2_addr=0, l2_wdata=0, i_resp=d_resp=0.
- Requester dropping its strobe mid-SERVE (protocol violation): arbiter keeps state until l2_resp; no recovery required.
- l2_resp while not in SERVE: ignored, not forwarded.

## Timing
- Reset (async, any time incl. mid-transaction): state=IDLE, last=1 (I wins first contention), counters=0, busy=0, l2 strobes=0, resps=0, addr/wdata=0. L2 transaction in flight is abandoned; its later l2_resp is ignored.
- Request visible in IDLE at edge N -> SERVE at cycle N+1, l2 strobe high in cycle N+1 (1-cycle grant latency).
- l2_resp in cycle M -> x_resp high in cycle M (combinational passthrough), RECOVER at M+1, IDLE at M+2; earliest next l2 strobe cycle M+3.
- busy = (state is SERVE_I or SERVE_D).
- Back-to-back contention alternates I, D, I, D; neither side waits more than one other transaction.

## Test plan
- Reset then single I read at addr 16'h0040; L2 returns line 128'hA5... with l2_resp 3 cycles after strobe -> l2_addr=16'h0040, l2_read=1 from cycle 1, i_resp one pulse with i_rdata=128'hA5..., d_resp=0, i_grant_cnt=1.
- After reset, I read and D write (addr 16'h1000, data 128'h1234...) asserted same cycle -> I served first, then D; l2_write=1 with l2_wdata=128'h1234... during D; counts 1/1.
- Both sides continuously requesting for 6 transactions -> grant order I,D,I,D,I,D; RECOVER cycle between each with all strobes 0.
- D asserts read and write together -> l2_write=1, l2_read=0.
- Assert reset 2 cycles into a D transaction, release, then raise l2_resp -> no d_resp, state IDLE, counters 0.
- Force i_grant_cnt to 16'hFFFE via 2 more grants beyond preload (or long run) -> saturates at 16'hFFFF, no wrap.
